// File: rtl/sha_pkg.sv
// Shared types, constants and helpers for the SHA-256 message feeder.
package sha_pkg;

    localparam logic [7:0] SHA_START_CODE = 8'd17;
    localparam int         SHA_LEN_W      = 64;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FILL, ST_PAD, ST_ISSUE, ST_WAIT, ST_CLEAR, ST_OUT
    } sha_state_t;

    // Commands understood by the block slot writer.
    typedef enum logic [2:0] {
        PC_NONE, PC_CLEAR, PC_WORD, PC_LAST, PC_EMPTY, PC_LENGTH, PC_TAIL, PC_DIGEST
    } pad_cmd_t;

    // H0..H7 initial values, IV[0] = H0.
    localparam logic [0:7][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [255:0] word_reverse256(input logic [255:0] v);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = v[255-32*k -: 32];
        return r;
    endfunction

    // IV in the core's chaining order: H0 in the least significant word.
    function automatic logic [255:0] iv_core();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = IV[k];
        return r;
    endfunction

    function automatic logic [2:0] last_bytes(input logic [1:0] nb);
        return (nb == 2'd0) ? 3'd4 : {1'b0, nb};
    endfunction

    // Keep the valid leading bytes of the final word and append the 0x80 marker if it fits.
    function automatic logic [31:0] pad_last_word(input logic [31:0] d, input logic [1:0] nb);
        case (nb)
            2'd1:    return {d[31:24], 24'h80_0000};
            2'd2:    return {d[31:16], 16'h8000};
            2'd3:    return {d[31:8], 8'h80};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/sha_pad_block.sv
// Registered 16-slot message block writer; presents the block in core word order.
module sha_pad_block
    import sha_pkg::*;
#(
    parameter int LEN_W = SHA_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  pad_cmd_t         cmd,
    input  logic [3:0]       idx,
    input  logic [31:0]      data,
    input  logic [1:0]       nbytes,
    input  logic             lead_pad,
    input  logic [LEN_W-1:0] bit_len,
    input  logic [255:0]     digest_in,
    output logic [511:0]     block
);

    logic [31:0] slot_reg [16];
    logic [63:0] len64;

    assign len64 = 64'(bit_len);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) slot_reg[i] <= '0;
        end else begin
            case (cmd)
                PC_CLEAR: for (int i = 0; i < 16; i++) slot_reg[i] <= '0;
                PC_WORD:  slot_reg[idx] <= data;
                PC_LAST: begin
                    slot_reg[idx] <= pad_last_word(data, nbytes);
                    // A full final word pushes the marker into the next slot (or the next block at slot 15).
                    if (nbytes == 2'd0 && idx != 4'd15) slot_reg[idx + 4'd1] <= 32'h8000_0000;
                end
                PC_EMPTY: slot_reg[idx] <= 32'h8000_0000;
                PC_LENGTH: begin
                    slot_reg[14] <= len64[63:32];
                    slot_reg[15] <= len64[31:0];
                end
                PC_TAIL: begin
                    for (int i = 1; i < 14; i++) slot_reg[i] <= '0;
                    slot_reg[0]  <= lead_pad ? 32'h8000_0000 : 32'h0;
                    slot_reg[14] <= len64[63:32];
                    slot_reg[15] <= len64[31:0];
                end
                PC_DIGEST: begin
                    for (int i = 0; i < 8; i++) slot_reg[i] <= digest_in[255-32*i -: 32];
                    slot_reg[8] <= 32'h8000_0000;
                    for (int i = 9; i < 15; i++) slot_reg[i] <= '0;
                    slot_reg[15] <= 32'd256;
                end
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_slot
            assign block[511-32*gi -: 32] = slot_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/sha_msg_feeder.sv
// Pads a word-streamed message into 512-bit blocks, sequences the SHA-256 core and returns the digest.
// Build option SHA_MSG_FEEDER_DOUBLE_EN rehashes the digest once more (SHA256d).
module sha_msg_feeder
    import sha_pkg::*;
#(
    parameter logic [7:0] START_CODE = SHA_START_CODE,
    parameter int         LEN_W      = SHA_LEN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  msg_data,
    input  logic         msg_valid,
    input  logic         msg_last,
    input  logic [1:0]   msg_bytes,
    input  logic         msg_empty,
    output logic         msg_ready,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [7:0]   core_start,
    output logic [511:0] core_block,
    output logic [255:0] core_h_in,
    output logic         core_reset,
    input  logic [255:0] core_h_out,
    input  logic         core_done
);

    sha_state_t       state_reg, state_next;
    logic [4:0]       idx_reg, idx_next;
    logic [4:0]       pad_slot_reg, pad_slot_next;
    logic [LEN_W-1:0] bit_len_reg, bit_len_next;
    logic             final_reg, final_next;
    logic             second_reg, second_next;
    logic [255:0]     h_in_reg, h_in_next;
    logic [255:0]     digest_reg, digest_next;
    logic             digest_valid_reg, digest_valid_next;
    logic [7:0]       core_start_reg;
    logic             core_reset_reg;
    pad_cmd_t         cmd;
`ifdef SHA_MSG_FEEDER_DOUBLE_EN
    logic             pass_reg, pass_next;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            idx_reg          <= '0;
            pad_slot_reg     <= '0;
            bit_len_reg      <= '0;
            final_reg        <= 1'b0;
            second_reg       <= 1'b0;
            h_in_reg         <= iv_core();
            digest_reg       <= '0;
            digest_valid_reg <= 1'b0;
            core_start_reg   <= '0;
            core_reset_reg   <= 1'b1;
`ifdef SHA_MSG_FEEDER_DOUBLE_EN
            pass_reg         <= 1'b0;
`endif
        end else begin
            state_reg        <= state_next;
            idx_reg          <= idx_next;
            pad_slot_reg     <= pad_slot_next;
            bit_len_reg      <= bit_len_next;
            final_reg        <= final_next;
            second_reg       <= second_next;
            h_in_reg         <= h_in_next;
            digest_reg       <= digest_next;
            digest_valid_reg <= digest_valid_next;
            core_start_reg   <= (state_next == ST_ISSUE) ? START_CODE : 8'd0;
            core_reset_reg   <= (state_next == ST_CLEAR);
`ifdef SHA_MSG_FEEDER_DOUBLE_EN
            pass_reg         <= pass_next;
`endif
        end
    end

    always_comb begin
        state_next        = state_reg;
        idx_next          = idx_reg;
        pad_slot_next     = pad_slot_reg;
        bit_len_next      = bit_len_reg;
        final_next        = final_reg;
        second_next       = second_reg;
        h_in_next         = h_in_reg;
        digest_next       = digest_reg;
        digest_valid_next = digest_valid_reg;
        cmd               = PC_NONE;
        msg_ready         = 1'b0;
`ifdef SHA_MSG_FEEDER_DOUBLE_EN
        pass_next         = pass_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                cmd         = PC_CLEAR;
                idx_next    = '0;
                final_next  = 1'b0;
                second_next = 1'b0;
                state_next  = ST_FILL;
            end
            ST_FILL: begin
                msg_ready = (idx_reg < 5'd16);
                if (msg_valid && msg_ready) begin
                    if (msg_last) begin
                        if (msg_empty) begin
                            cmd           = PC_EMPTY;
                            pad_slot_next = idx_reg;
                        end else begin
                            cmd           = PC_LAST;
                            bit_len_next  = bit_len_reg + LEN_W'({last_bytes(msg_bytes), 3'b000});
                            pad_slot_next = (msg_bytes == 2'd0) ? idx_reg + 5'd1 : idx_reg;
                        end
                        state_next = ST_PAD;
                    end else begin
                        cmd          = PC_WORD;
                        bit_len_next = bit_len_reg + LEN_W'(32);
                        idx_next     = idx_reg + 5'd1;
                        if (idx_reg == 5'd15) state_next = ST_ISSUE;
                    end
                end
            end
            ST_PAD: begin
                // Length needs slots 14-15 free; otherwise a trailing length-only block follows.
                if (second_reg) begin
                    cmd         = PC_TAIL;
                    final_next  = 1'b1;
                    second_next = 1'b0;
                end else if (pad_slot_reg <= 5'd13) begin
                    cmd        = PC_LENGTH;
                    final_next = 1'b1;
                end else begin
                    second_next = 1'b1;
                end
                state_next = ST_ISSUE;
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (core_done) begin
                    h_in_next  = word_reverse256(core_h_out);
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cmd      = PC_CLEAR;
                idx_next = '0;
                if (final_reg) begin
`ifdef SHA_MSG_FEEDER_DOUBLE_EN
                    if (!pass_reg) begin
                        cmd        = PC_DIGEST;
                        pass_next  = 1'b1;
                        h_in_next  = iv_core();
                        state_next = ST_ISSUE;
                    end else begin
                        digest_next       = word_reverse256(h_in_reg);
                        digest_valid_next = 1'b1;
                        state_next        = ST_OUT;
                    end
`else
                    digest_next       = word_reverse256(h_in_reg);
                    digest_valid_next = 1'b1;
                    state_next        = ST_OUT;
`endif
                end else if (second_reg) begin
                    state_next = ST_PAD;
                end else begin
                    state_next = ST_FILL;
                end
            end
            ST_OUT: begin
                if (digest_ready) begin
                    digest_valid_next = 1'b0;
                    bit_len_next      = '0;
                    h_in_next         = iv_core();
                    final_next        = 1'b0;
                    second_next       = 1'b0;
`ifdef SHA_MSG_FEEDER_DOUBLE_EN
                    pass_next         = 1'b0;
`endif
                    state_next        = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    sha_pad_block #(.LEN_W(LEN_W)) u_pad (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd),
        .idx       (idx_reg[3:0]),
        .data      (msg_data),
        .nbytes    (msg_bytes),
        .lead_pad  (pad_slot_reg == 5'd16),
        .bit_len   (bit_len_reg),
        .digest_in (word_reverse256(h_in_reg)),
        .block     (core_block)
    );

    assign digest       = digest_reg;
    assign digest_valid = digest_valid_reg;
    assign core_start   = core_start_reg;
    assign core_reset   = core_reset_reg;
    assign core_h_in    = h_in_reg;

endmodule

// File: tb/tb_sha_msg_feeder.sv
// Directed bench for sha_msg_feeder with a behavioural SHA-256 compression core.
module tb_sha_msg_feeder;

    localparam logic [255:0] IV_STD  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV_CORE = 256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
    localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_56    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam int LAT = 67;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  msg_data;
    logic         msg_valid, msg_last, msg_empty;
    logic [1:0]   msg_bytes;
    logic         msg_ready;
    logic [255:0] digest;
    logic         digest_valid, digest_ready;
    logic [7:0]   core_start;
    logic [511:0] core_block;
    logic [255:0] core_h_in;
    logic         core_reset;
    logic [255:0] core_h_out = '0;
    logic         core_done = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [7:0] msg_buf [0:127];

    always #5 clk = ~clk;

    sha_msg_feeder dut (
        .clk(clk), .reset(reset),
        .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last),
        .msg_bytes(msg_bytes), .msg_empty(msg_empty), .msg_ready(msg_ready),
        .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready),
        .core_start(core_start), .core_block(core_block), .core_h_in(core_h_in),
        .core_reset(core_reset), .core_h_out(core_h_out), .core_done(core_done)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] rev256(input logic [255:0] v);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = v[255-32*k -: 32];
        return r;
    endfunction

    // One SHA-256 compression; h has H0 in [255:224].
    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-7]
                 + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    function automatic logic [255:0] sw_sha256(input int len);
        logic [7:0]   p [0:191];
        logic [255:0] h;
        logic [511:0] blk;
        logic [63:0]  bits;
        int nb;
        nb = (len + 9 + 63) / 64;
        for (int i = 0; i < 192; i++) p[i] = (i < len) ? msg_buf[i] : 8'h00;
        p[len] = 8'h80;
        bits = 64'(len * 8);
        for (int j = 0; j < 8; j++) p[nb*64-1-j] = bits[8*j +: 8];
        h = IV_STD;
        for (int bi = 0; bi < nb; bi++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*bi+j];
            h = sha_compress(h, blk);
        end
        return h;
    endfunction

    function automatic logic [255:0] expv(input logic [255:0] single);
`ifdef SHA_MSG_FEEDER_DOUBLE_EN
        logic [511:0] blk;
        blk = {single, 32'h8000_0000, 160'd0, 64'd256};
        return sha_compress(IV_STD, blk);
`else
        return single;
`endif
    endfunction

    function automatic int blocks_for(input int len);
`ifdef SHA_MSG_FEEDER_DOUBLE_EN
        return (len + 9 + 63) / 64 + 1;
`else
        return (len + 9 + 63) / 64;
`endif
    endfunction

    // Behavioural core: starts on START_CODE, raises done after LAT cycles, holds it until core_reset.
    logic         core_busy = 1'b0;
    int           core_cnt = 0;
    int           start_cycles = 0;
    int           unstable = 0;
    logic [511:0] blk_lat;
    logic [255:0] hin_lat;

    always @(posedge clk) begin
        if (core_start != 8'd0) start_cycles <= start_cycles + 1;
        if (core_reset) begin
            core_done <= 1'b0;
            core_busy <= 1'b0;
        end else if (core_busy) begin
            if (core_block !== blk_lat || core_h_in !== hin_lat) unstable <= unstable + 1;
            if (core_cnt <= 1) begin
                core_busy <= 1'b0;
                core_done <= 1'b1;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end else if (core_start == 8'd17 && !core_done) begin
            core_busy  <= 1'b1;
            core_cnt   <= LAT;
            blk_lat    <= core_block;
            hin_lat    <= core_h_in;
            core_h_out <= sha_compress(rev256(core_h_in), core_block);
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_msg(input int len);
        int nw;
        int g;
        logic [31:0] d;
        nw = (len == 0) ? 1 : (len + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            for (int bi = 0; bi < 4; bi++) d[31-8*bi -: 8] = (4*w + bi < len) ? msg_buf[4*w+bi] : 8'hA5;
            @(negedge clk);
            msg_valid = 1'b1;
            msg_data  = d;
            msg_last  = (w == nw - 1);
            msg_bytes = 2'(len % 4);
            msg_empty = (len == 0);
            g = 0;
            while (msg_ready !== 1'b1 && g < 500) begin
                @(negedge clk);
                g++;
            end
            if (g >= 500) chk("accept_timeout", msg_ready, 1);
            @(posedge clk);
        end
        @(negedge clk);
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        msg_empty = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int g;
        g = 0;
        while (digest_valid !== 1'b1 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_valid"}, digest_valid, 1);
    endtask

    task automatic run_test(input int len, input logic [255:0] exp, input string tag);
        int s0;
        s0 = start_cycles;
        send_msg(len);
        wait_valid(tag);
        chk(tag, digest, exp);
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
        chk({tag, "_taken"}, digest_valid, 0);
        chk({tag, "_starts"}, start_cycles - s0, blocks_for(len));
        $display("msg %s len=%0d digest=%h", tag, len, digest);
    endtask

    task automatic load_abc();
        msg_buf[0] = 8'h61;
        msg_buf[1] = 8'h62;
        msg_buf[2] = 8'h63;
    endtask

    task automatic load_pattern(input int seed);
        for (int i = 0; i < 128; i++) msg_buf[i] = 8'(i * 37 + seed);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] exp_abc;
        int g;
        exp_abc      = expv(D_ABC);
        reset        = 1'b0;
        msg_data     = '0;
        msg_valid    = 1'b0;
        msg_last     = 1'b0;
        msg_bytes    = 2'd0;
        msg_empty    = 1'b0;
        digest_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_msg_ready", msg_ready, 0);
        chk("rst_digest_valid", digest_valid, 0);
        chk("rst_digest", digest, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_core_block", core_block, 0);
        chk("rst_core_h_in", core_h_in, IV_CORE);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("fill_core_reset", core_reset, 0);
        chk("fill_msg_ready", msg_ready, 1);

        load_abc();
        run_test(3, exp_abc, "abc");
        run_test(0, expv(D_EMPTY), "empty");
        for (int i = 0; i < 56; i++) msg_buf[i] = 8'(8'h61 + (i / 4) + (i % 4));
        run_test(56, expv(D_56), "two_block_56");

        // Digest held under back-pressure while stray words are offered.
        load_abc();
        send_msg(3);
        wait_valid("stall");
        msg_valid = 1'b1;
        msg_data  = 32'hdeadbeef;
        msg_last  = 1'b1;
        msg_bytes = 2'd1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("stall_valid", digest_valid, 1);
            chk("stall_digest", digest, exp_abc);
            chk("stall_msg_ready", msg_ready, 0);
        end
        msg_valid    = 1'b0;
        msg_last     = 1'b0;
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
        chk("stall_taken", digest_valid, 0);
        chk("stall_idle_ready", msg_ready, 0);
        @(negedge clk);
        chk("stall_fill_ready", msg_ready, 1);
        $display("msg stall_hold cycles=20");
        run_test(3, exp_abc, "after_stall");

        // Abort during the first compression.
        send_msg(3);
        g = 0;
        while (!core_busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("abort_core_busy", core_busy, 1);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_core_reset", core_reset, 1);
        chk("abort_digest_valid", digest_valid, 0);
        chk("abort_digest", digest, 0);
        chk("abort_core_start", core_start, 0);
        chk("abort_msg_ready", msg_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        $display("msg abort_in_wait");
        run_test(3, exp_abc, "abc_after_abort");

        load_pattern(3);
        run_test(55, expv(sw_sha256(55)), "len55");
        run_test(60, expv(sw_sha256(60)), "len60");
        run_test(61, expv(sw_sha256(61)), "len61");
        load_pattern(11);
        run_test(64, expv(sw_sha256(64)), "len64");
        run_test(100, expv(sw_sha256(100)), "len100");
        run_test(6, expv(sw_sha256(6)), "len6");

        chk("block_hin_stable", unstable, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha_msg_feeder.md
Name: sha_msg_feeder

Overview:
Message-side initiator for the SHA-256 compression core. It accepts a byte-aligned message as a 32-bit word stream and applies FIPS 180-4 padding and length append. It assembles 512-bit blocks, drives the core's start/reset/done handshake block by block, and chains intermediate hashes. It emits the final 256-bit digest on a valid/ready output, and sits between the HPS-facing register/stream logic and the core.

Parameters:
START_CODE, 8'd17, value driven on core_start to launch one compression.
LEN_W, 64, width of the internal message bit-length counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
msg_data  in  32  message word, big-endian (first byte in [31:24])
msg_valid  in  1  msg_data valid
msg_last  in  1  final word of message (qualified by msg_valid)
msg_bytes  in  2  valid bytes in last word, counted from MSB; 0 means 4
msg_empty  in  1  with msg_valid&msg_last: zero-length message; msg_data ignored
msg_ready  out  1  feeder accepts word this cycle
digest  out  256  H0 in [255:224] .. H7 in [31:0]
digest_valid  out  1  digest held valid until taken
digest_ready  in  1  consumer accepts digest
core_start  out  8  start command to core
core_block  out  512  word i at [511-32i -: 32]; stable from ISSUE through WAIT
core_h_in  out  256  chaining value, core ordering: H0 in [31:0] .. H7 in [255:224]
core_reset  out  1  active-high reset pulse to core
core_h_out  in  256  core result, H0 in [255:224]
core_done  in  1  core in DONE state

Behaviour:
- Reset (reset=0, async): state IDLE, msg_ready=0, digest_valid=0, digest=0, core_start=0, core_reset=1 (held), core_block=0, core_h_in=IV, bit count=0, word index=0.
- States: IDLE -> FILL -> (PAD) -> ISSUE -> WAIT -> CLEAR -> FILL/PAD/OUT; OUT -> IDLE.
- IDLE: core_reset=0, msg_ready=0. Go to FILL next cycle. core_h_in=IV; IV constants live in the package.
- FILL: msg_ready=1 while word index<16. A word is taken on msg_valid&msg_ready. It goes into slot idx, and the bit count increases by 8*bytes. On a non-last word filling slot 15, go to ISSUE.
- Last word: keep its valid bytes. Write 0x80 into the next byte position, which may be the first byte of the next slot. Zero-fill the remainder, then go to PAD. msg_empty makes slot 0 = 32'h8000_0000.
- PAD (msg_ready=0): zero the remaining slots. If the 0x80 byte landed at slot<=13, put the bit length big-endian in slots 14 and 15 and mark final. Otherwise issue this block, and the following block is all zeros plus the length, marked final.
- ISSUE: core_start=START_CODE for exactly 1 cycle, then WAIT. At all other times core_start=0.
- WAIT: hold core_block and core_h_in until core_done=1. Nominal core latency is about 67 cycles after ISSUE.
- CLEAR, on the core_done cycle:
  - capture core_h_out;
  - set next core_h_in = word-reverse(core_h_out), i.e. core_h_in[32k+:32] = core_h_out[255-32k -: 32];
  - pulse core_reset=1 for 1 cycle;
  - next state: not final -> FILL (idx=0) or PAD (second padding block); final -> OUT.
- OUT: digest = captured core_h_out, digest_valid=1, held until digest_ready. On transfer: digest_valid=0, bit count=0, core_h_in=IV, go to IDLE.
- Length arithmetic is modulo 2^LEN_W. msg_valid while msg_ready=0 is ignored (no drop, no accept).
- Reset mid-operation aborts everything. No partial digest is emitted; core_reset is asserted.

Optional Feature:
SHA_MSG_FEEDER_DOUBLE_EN.
- Defined: after the final block, the 256-bit digest is hashed again as a one-block message: digest || 0x80 || zeros || length 256. The chain restarts from IV, and only the second digest is output (Bitcoin-style SHA256d). Adds about 70 cycles.
- Undefined: single SHA-256 only.

Decomposition:
Package sha_pkg:
- state enum;
- IV[0:7];
- START_CODE default;
- function word_reverse256.

One sub-module, sha_pad_block: a combinational/registered slot writer that takes the word index, byte count and length and produces the 512-bit block. The FSM stays in sha_msg_feeder. The bench uses a behavioural core model or the real core.

Test Plan:
- "abc" (1 word, msg_bytes=3, last) -> 1 block, digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- msg_empty -> 1 block, digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- 56-byte "abcdbcdecdefdefg...nopq" (14 words) -> 2 core starts, digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- digest_ready held low 20 cycles -> digest_valid and digest stable; msg_ready=0 throughout; release -> IDLE.
- reset low during WAIT of block 1 -> core_reset=1, digest_valid=0; re-run "abc" -> correct digest.
- DOUBLE_EN build, "abc" -> 2 core starts, digest equals software SHA256(SHA256("abc")) from the golden model.
